// File: rtl/user_bram_wb.sv
// user_bram_wb -- Wishbone-B4 classic slave for the user-project code/data RAM.
//
// The management core fetches and executes firmware from this RAM and reads and
// writes data in it. Every access completes after a fixed number of wait states
// (DELAYS) so the block behaves like slow on-chip BRAM.
//
// Ports:
//   wb_clk_i   single clock, all logic on the rising edge
//   wb_rstn_i  asynchronous active-low reset, synchronous release
//   wbs_cyc_i  bus cycle valid
//   wbs_stb_i  strobe
//   wbs_we_i   1 = write, 0 = read
//   wbs_sel_i  byte lane enables, bit n selects data bits [8n+7:8n]
//   wbs_adr_i  byte address; [31:24] selects the window, [ADDR_WIDTH+1:2] the word
//   wbs_dat_i  write data
//   wbs_ack_o  single-cycle transfer acknowledge
//   wbs_dat_o  read data, held until the next read acknowledge
module user_bram_wb #(
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DELAYS     = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int unsigned Depth    = 1 << ADDR_WIDTH;
    localparam logic [7:0]  DelayCnt = 8'(DELAYS);

    // Request decode
    logic                  hit;
    logic                  fire;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] idx;

    // Wait counter and bus outputs
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    // Storage; deliberately not reset so it maps onto block RAM.
    logic [31:0] mem_q [Depth];

    // Address bits that only alias inside the window.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:ADDR_WIDTH+2], wbs_adr_i[1:0], BASE_ADDR[23:0]};

    assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign idx = wbs_adr_i[ADDR_WIDTH+1:2];

    // The edge that raises ack is the one that commits the access. ack_q low keeps a
    // held strobe from re-firing in the ack cycle itself.
    assign fire  = hit & ~ack_q & (cnt_q == DelayCnt);
    // Gate with reset so a request held through reset cannot write the RAM.
    assign wr_en = fire & wbs_we_i & wb_rstn_i;
    assign rd_en = fire & ~wbs_we_i;

    always_comb begin
        cnt_d = 8'd0;
        ack_d = 1'b0;
        dat_d = dat_q;
        if (fire) begin
            ack_d = 1'b1;
            cnt_d = 8'd0;
        end else if (hit && !ack_q) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (rd_en) begin
            dat_d = mem_q[idx];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            cnt_q <= 8'd0;
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    // Synchronous byte-enabled write port.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (wbs_sel_i[n]) begin
                    mem_q[idx][8*n +: 8] <= wbs_dat_i[8*n +: 8];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_user_bram_wb.sv
module tb_user_bram_wb;

    localparam int Delays = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic        cyc0 = 1'b0, stb0 = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic        ack, ack0;
    logic [31:0] dat_o, dat_o0;

    int vectors = 0;
    int errors  = 0;

    // Reference model: word store keyed by word index, plus last read value.
    logic [31:0] model_mem [int];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    user_bram_wb #(.BASE_ADDR(32'h3800_0000), .ADDR_WIDTH(10), .DELAYS(Delays)) u_dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rstn),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o)
    );

    user_bram_wb #(.BASE_ADDR(32'h3800_0000), .ADDR_WIDTH(10), .DELAYS(0)) u_dut0 (
        .wb_clk_i (clk),
        .wb_rstn_i(rstn),
        .wbs_cyc_i(cyc0),
        .wbs_stb_i(stb0),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack0),
        .wbs_dat_o(dat_o0)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int n = 0; n < 4; n++) begin
            if (s[n]) r = (r & ~(32'hFF << (8 * n))) | (d & (32'hFF << (8 * n)));
        end
        return r;
    endfunction

    // Full transfer on the main DUT; returns edges from request to ack.
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int edges, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        edges = 0;
        while (edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (ack === 1'b1) break;
        end
        rd = dat_o;
        vectors++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL xfer_timeout adr=%h got ack=%b want 1 within 300 edges", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #12;
        vectors++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got ack=%b dat=%h want 0/00000000", ack, dat_o);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int e;
        logic [31:0] rd;
        bus_xfer(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, e, rd);
        model_mem[widx(32'h3800_0010)] = 32'hDEAD_BEEF;
        vectors++;
        if (e !== Delays + 1) begin
            errors++; $display("FAIL write_latency got %0d edges want %0d", e, Delays + 1);
        end
        vectors++;
        if (rd !== last_rd) begin
            errors++; $display("FAIL dat_hold_on_write got %h want %h", rd, last_rd);
        end
        bus_xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, e, rd);
        last_rd = model_mem[4];
        vectors++;
        if (e !== Delays + 1) begin
            errors++; $display("FAIL read_latency got %0d edges want %0d", e, Delays + 1);
        end
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_back got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_lanes;
        int e;
        logic [31:0] rd;
        bus_xfer(1'b1, 32'h3800_0020, 32'h1122_3344, 4'hF, e, rd);
        bus_xfer(1'b1, 32'h3800_0020, 32'hAABB_CCDD, 4'b0101, e, rd);
        model_mem[8] = merge(32'h1122_3344, 32'hAABB_CCDD, 4'b0101);
        bus_xfer(1'b0, 32'h3800_0020, 32'h0, 4'hF, e, rd);
        vectors++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL byte_lanes got %h want 11bb33dd", rd);
        end
        // sel = 0 acks but changes nothing; read back through an aliased address.
        bus_xfer(1'b1, 32'h3800_0020, 32'hFFFF_FFFF, 4'h0, e, rd);
        bus_xfer(1'b0, 32'h38FF_F023, 32'h0, 4'hF, e, rd);
        last_rd = model_mem[8];
        vectors++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL sel0_alias got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_abort;
        int e;
        logic [31:0] rd;
        logic saw = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0010; dat = 32'h5555_5555;
        sel = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) saw = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL abort_ack got ack=1 want 0");
        end
        bus_xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, e, rd);
        last_rd = model_mem[4];
        vectors++;
        if (e !== Delays + 1) begin
            errors++; $display("FAIL abort_restart got %0d edges want %0d", e, Delays + 1);
        end
        vectors++;
        if (rd !== model_mem[4]) begin
            errors++; $display("FAIL abort_nowrite got %h want %h", rd, model_mem[4]);
        end
    endtask

    task automatic test_out_of_window;
        int e;
        logic [31:0] rd;
        logic saw = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; dat = 32'h0F0F_0F0F;
        sel = 4'hF;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) saw = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL oow_ack got ack=1 want 0");
        end
        bus_xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, e, rd);
        last_rd = model_mem[4];
        vectors++;
        if (rd !== model_mem[4]) begin
            errors++; $display("FAIL oow_nowrite got %h want %h", rd, model_mem[4]);
        end
    endtask

    task automatic test_reset_mid_wait;
        int e;
        logic [31:0] rd;
        bus_xfer(1'b1, 32'h3800_0030, 32'h0BAD_C0DE, 4'hF, e, rd);
        model_mem[12] = 32'h0BAD_C0DE;
        bus_xfer(1'b0, 32'h3800_0030, 32'h0, 4'hF, e, rd);
        last_rd = 32'h0BAD_C0DE;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0030; dat = 32'hCAFE_F00D;
        sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if (ack !== 1'b0 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait got ack=%b dat=%h want 0/00000000", ack, dat_o);
        end
        last_rd = 32'h0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        bus_xfer(1'b0, 32'h3800_0030, 32'h0, 4'hF, e, rd);
        last_rd = model_mem[12];
        vectors++;
        if (rd !== 32'h0BAD_C0DE) begin
            errors++; $display("FAIL reset_nowrite got %h want 0badc0de", rd);
        end
    endtask

    task automatic test_back_to_back;
        int e = 0;
        int gap = 0;
        int width = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0044; dat = 32'h2468_ACE0;
        sel = 4'hF;
        while (e < 300) begin
            @(posedge clk); #1;
            e++;
            if (ack === 1'b1) break;
        end
        model_mem[17] = 32'h2468_ACE0;
        // Strobe stays high: switch straight to a read of the same word.
        we = 1'b0;
        while (gap < 300) begin
            @(posedge clk); #1;
            gap++;
            if (ack === 1'b1) break;
            if (gap == 1 && ack === 1'b0) width = 1;
        end
        cyc = 1'b0; stb = 1'b0;
        vectors++;
        if (gap !== Delays + 2) begin
            errors++; $display("FAIL b2b_period got %0d edges want %0d", gap, Delays + 2);
        end
        vectors++;
        if (width !== 1) begin
            errors++; $display("FAIL ack_one_cycle got width flag %0d want 1", width);
        end
        vectors++;
        if (dat_o !== 32'h2468_ACE0) begin
            errors++; $display("FAIL b2b_read got %h want 2468ace0", dat_o);
        end
        last_rd = 32'h2468_ACE0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_delay;
        int e;
        cyc0 = 1'b1; stb0 = 1'b1; we = 1'b1; adr = 32'h3800_0040; dat = 32'h1357_9BDF;
        sel = 4'hF;
        e = 0;
        while (e < 20) begin
            @(posedge clk); #1;
            e++;
            if (ack0 === 1'b1) break;
        end
        cyc0 = 1'b0; stb0 = 1'b0;
        vectors++;
        if (e !== 1) begin
            errors++; $display("FAIL zero_delay_latency got %0d edges want 1", e);
        end
        @(posedge clk); #1;
        cyc0 = 1'b1; stb0 = 1'b1; we = 1'b0;
        e = 0;
        while (e < 20) begin
            @(posedge clk); #1;
            e++;
            if (ack0 === 1'b1) break;
        end
        cyc0 = 1'b0; stb0 = 1'b0;
        vectors++;
        if (e !== 1 || dat_o0 !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL zero_delay_read got %0d edges dat=%h want 1 edge 13579bdf", e, dat_o0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int pool [6] = '{100, 101, 511, 512, 777, 1023};
        int e;
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic        w;
        for (int it = 0; it < 30; it++) begin
            int k = pool[$urandom_range(0, 5)];
            a = 32'h3800_0000 | (32'($urandom_range(0, 4095)) << 12) | (32'(k) << 2)
                | 32'($urandom_range(0, 3));
            d = $urandom;
            w = ($urandom_range(0, 1) == 1) || !model_mem.exists(k);
            s = model_mem.exists(k) ? 4'($urandom_range(0, 15)) : 4'hF;
            bus_xfer(w, a, d, s, e, rd);
            if (w) begin
                model_mem[k] = merge(model_mem.exists(k) ? model_mem[k] : 32'h0, d, s);
            end else begin
                last_rd = model_mem[k];
            end
            vectors++;
            if (e !== Delays + 1 || rd !== last_rd) begin
                errors++;
                $display("FAIL random_%0d we=%b adr=%h got %0d edges dat=%h want %0d %h",
                         it, w, a, e, rd, Delays + 1, last_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_abort();
        test_out_of_window();
        test_reset_mid_wait();
        test_back_to_back();
        test_zero_delay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
